// File: rtl/pid_pkg.sv
// Shared types and constants for the attitude PID sequencer and its MAC datapath.
package pid_pkg;
    typedef enum logic [2:0] {IDLE, ERR, WAIT, MAC, OUT} state_t;

    localparam int TERM_P = 0;
    localparam int TERM_I = 1;
    localparam int TERM_D = 2;

    localparam int AXIS_PITCH = 0;
    localparam int AXIS_ROLL  = 1;
    localparam int AXIS_YAW   = 2;
    localparam int NUM_AXES   = 3;

    localparam int DEFAULT_W     = 24;
    localparam int DEFAULT_KW    = 16;
    localparam int DEFAULT_KFRAC = 8;
    localparam int DEFAULT_OW    = 16;
endpackage

// File: rtl/pid_sequencer_if.sv
// Sample handshake, error/gain inputs and command outputs of the PID sequencer.
interface pid_sequencer_if
    import pid_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int KW = DEFAULT_KW,
    parameter int OW = DEFAULT_OW
);
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 err_en;
    logic [3*W-1:0]       p_err;
    logic [3*W-1:0]       i_err;
    logic [3*W-1:0]       d_err;
    logic [3*KW-1:0]      kp;
    logic [3*KW-1:0]      ki;
    logic [3*KW-1:0]      kd;
    logic                 clr_overrun;
    logic signed [OW-1:0] u_pitch;
    logic signed [OW-1:0] u_roll;
    logic signed [OW-1:0] u_yaw;
    logic                 u_valid;
    logic [2:0]           sat;
    logic                 busy;
    logic                 overrun;

    modport master (
        output sample_valid, p_err, i_err, d_err, kp, ki, kd, clr_overrun,
        input  sample_ready, err_en, u_pitch, u_roll, u_yaw, u_valid, sat, busy, overrun
    );

    modport slave (
        input  sample_valid, p_err, i_err, d_err, kp, ki, kd, clr_overrun,
        output sample_ready, err_en, u_pitch, u_roll, u_yaw, u_valid, sat, busy, overrun
    );
endinterface

// File: rtl/pid_mac.sv
// Shared signed multiply-accumulate with floor shift and symmetric output saturation.
module pid_mac
    import pid_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int KW    = DEFAULT_KW,
    parameter int KFRAC = DEFAULT_KFRAC,
    parameter int OW    = DEFAULT_OW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic signed [W-1:0]  err,
    input  logic signed [KW-1:0] gain,
    output logic signed [OW-1:0] result,
    output logic                 clamped
);
    localparam int PW = W + KW;
    localparam int AW = PW + 2;
    localparam logic signed [AW-1:0] MAX_OUT = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_OUT = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [PW-1:0] product;
    logic signed [AW-1:0] product_ext;
    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] shifted;

    assign product     = err * gain;
    assign product_ext = {{(AW-PW){product[PW-1]}}, product};
    assign acc_next    = load ? product_ext : acc_reg + product_ext;
    // The result is taken from acc_next so the D term's edge can store it directly.
    assign shifted     = acc_next >>> KFRAC;

    always_comb begin
        result  = shifted[OW-1:0];
        clamped = 1'b0;
        if (shifted > MAX_OUT) begin
            result  = MAX_OUT[OW-1:0];
            clamped = 1'b1;
        end else if (shifted < MIN_OUT) begin
            result  = MIN_OUT[OW-1:0];
            clamped = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_next;
        end
    end
endmodule

// File: rtl/pid_sequencer.sv
// Attitude PID sequencer: triggers error calculation, snapshots errors/gains and
// time-multiplexes one MAC over 3 axes x 3 terms to produce saturated commands.
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int KW      = DEFAULT_KW,
    parameter int KFRAC   = DEFAULT_KFRAC,
    parameter int OW      = DEFAULT_OW,
    parameter int ERR_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    pid_sequencer_if.slave bus
);
    localparam int WCW = (ERR_LAT > 1) ? $clog2(ERR_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(ERR_LAT - 1);

    state_t state_reg, state_next;
    logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0] axis_reg, axis_next;
    logic [1:0] term_reg, term_next;
    logic capture, mac_en, last_mac;

    logic signed [W-1:0]  p_axis [NUM_AXES];
    logic signed [W-1:0]  i_axis [NUM_AXES];
    logic signed [W-1:0]  d_axis [NUM_AXES];
    logic signed [KW-1:0] kp_axis [NUM_AXES];
    logic signed [KW-1:0] ki_axis [NUM_AXES];
    logic signed [KW-1:0] kd_axis [NUM_AXES];

    logic signed [W-1:0]  err_snap_reg  [NUM_AXES][3];
    logic signed [KW-1:0] gain_snap_reg [NUM_AXES][3];
    logic signed [OW-1:0] shadow_reg [NUM_AXES];
    logic [NUM_AXES-1:0]  shadow_sat_reg;
    logic signed [OW-1:0] u_reg [NUM_AXES];
    logic [NUM_AXES-1:0]  sat_reg;
    logic                 u_valid_reg;
    logic                 overrun_reg;

    logic signed [OW-1:0] mac_result;
    logic                 mac_clamped;

    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
        assign p_axis[gi]  = bus.p_err[gi*W +: W];
        assign i_axis[gi]  = bus.i_err[gi*W +: W];
        assign d_axis[gi]  = bus.d_err[gi*W +: W];
        assign kp_axis[gi] = bus.kp[gi*KW +: KW];
        assign ki_axis[gi] = bus.ki[gi*KW +: KW];
        assign kd_axis[gi] = bus.kd[gi*KW +: KW];
    end

    assign bus.sample_ready = (state_reg == IDLE);
    assign bus.busy         = (state_reg != IDLE);
    assign bus.err_en       = (state_reg == ERR);
    assign bus.u_pitch      = u_reg[AXIS_PITCH];
    assign bus.u_roll       = u_reg[AXIS_ROLL];
    assign bus.u_yaw        = u_reg[AXIS_YAW];
    assign bus.sat          = sat_reg;
    assign bus.u_valid      = u_valid_reg;
    assign bus.overrun      = overrun_reg;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        axis_next     = axis_reg;
        term_next     = term_reg;
        capture       = 1'b0;
        mac_en        = 1'b0;
        last_mac      = 1'b0;
        case (state_reg)
            IDLE: if (bus.sample_valid) state_next = ERR;
            ERR: begin
                state_next    = WAIT;
                wait_cnt_next = WAIT_LOAD;
            end
            WAIT: begin
                if (wait_cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = MAC;
                    axis_next  = 2'(AXIS_PITCH);
                    term_next  = 2'(TERM_P);
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (term_reg == 2'(TERM_D)) begin
                    term_next = 2'(TERM_P);
                    axis_next = axis_reg + 1'b1;
                    if (axis_reg == 2'(AXIS_YAW)) begin
                        last_mac   = 1'b1;
                        state_next = OUT;
                    end
                end else begin
                    term_next = term_reg + 1'b1;
                end
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            axis_reg     <= '0;
            term_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            axis_reg     <= axis_next;
            term_reg     <= term_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                for (int t = 0; t < 3; t++) begin
                    err_snap_reg[a][t]  <= '0;
                    gain_snap_reg[a][t] <= '0;
                end
            end
        end else if (capture) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                err_snap_reg[a][TERM_P]  <= p_axis[a];
                err_snap_reg[a][TERM_I]  <= i_axis[a];
                err_snap_reg[a][TERM_D]  <= d_axis[a];
                gain_snap_reg[a][TERM_P] <= kp_axis[a];
                gain_snap_reg[a][TERM_I] <= ki_axis[a];
                gain_snap_reg[a][TERM_D] <= kd_axis[a];
            end
        end
    end

    pid_mac #(.W(W), .KW(KW), .KFRAC(KFRAC), .OW(OW)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .en      (mac_en),
        .load    (term_reg == 2'(TERM_P)),
        .err     (err_snap_reg[axis_reg][term_reg]),
        .gain    (gain_snap_reg[axis_reg][term_reg]),
        .result  (mac_result),
        .clamped (mac_clamped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                shadow_reg[a] <= '0;
                u_reg[a]      <= '0;
            end
            shadow_sat_reg <= '0;
            sat_reg        <= '0;
            u_valid_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            u_valid_reg <= 1'b0;
            if (mac_en && term_reg == 2'(TERM_D)) begin
                shadow_reg[axis_reg]     <= mac_result;
                shadow_sat_reg[axis_reg] <= mac_clamped;
            end
            // Yaw bypasses its shadow so the commands are already valid during OUT.
            if (last_mac) begin
                u_reg[AXIS_PITCH] <= shadow_reg[AXIS_PITCH];
                u_reg[AXIS_ROLL]  <= shadow_reg[AXIS_ROLL];
                u_reg[AXIS_YAW]   <= mac_result;
                sat_reg           <= {mac_clamped, shadow_sat_reg[AXIS_ROLL], shadow_sat_reg[AXIS_PITCH]};
                u_valid_reg       <= 1'b1;
            end
            if (bus.sample_valid && state_reg != IDLE) begin
                overrun_reg <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_reg <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pid_sequencer.md
# pid_sequencer

Control-loop sequencer for the attitude PID path. Accepts a new attitude sample, pulses `cal_error_en` on the error-calculation block for exactly one cycle, snapshots its P/I/D errors, then time-multiplexes one shared multiply-accumulate unit over 3 axes × 3 terms. It produces saturated per-axis correction commands for the motor mixer.

## Interface
- `W`, 24: error width (signed two's complement)
- `KW`, 16: gain width (signed)
- `KFRAC`, 8: fractional bits of gains
- `OW`, 16: command output width (signed)
- `ERR_LAT`, 1: cycles from `err_en` edge to valid error inputs (≥1)

- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `sample_valid`  in  1  new attitude sample available
- `sample_ready`  out  1  high only in IDLE
- `err_en`  out  1  drives `cal_error_en`; one-cycle pulse
- `p_err`, `i_err`, `d_err`  in  3*W each  packed {yaw,roll,pitch} errors
- `kp`, `ki`, `kd`  in  3*KW each  packed {yaw,roll,pitch} gains
- `clr_overrun`  in  1  clears `overrun`
- `u_pitch`, `u_roll`, `u_yaw`  out  OW each  signed commands
- `u_valid`  out  1  one-cycle pulse when new commands are presented
- `sat`  out  3  {yaw,roll,pitch} saturated on the last update
- `busy`  out  1  state ≠ IDLE
- `overrun`  out  1  sticky dropped-sample flag

## Operation
- States: IDLE → ERR → WAIT → MAC → OUT → IDLE.
- IDLE: `sample_ready`=1. `sample_valid`=1 is accepted and moves the FSM to ERR.
- ERR: one cycle with `err_en`=1. The FSM then moves to WAIT.
- WAIT: down-counter of ERR_LAT cycles. On the final WAIT edge, all nine errors and nine gains are captured into snapshot registers. The FSM then moves to MAC with k=0.
- MAC: nine cycles, k=0..8. Axis = k/3 (pitch, roll, yaw); term = k%3 (P, I, D).
  - Each cycle computes product = err × gain, signed, W+KW bits.
  - On term P, the accumulator is loaded with the product. On I and D, the product is added. Accumulator width is W+KW+2.
  - On term D:
    - Form r = acc >>> KFRAC (arithmetic shift, floor).
    - Saturate r to [−2^(OW−1), 2^(OW−1)−1] and write it to the axis shadow register.
    - Set the shadow sat bit when clamping occurs.
- OUT: shadow registers are copied to `u_*` and `sat`, with `u_valid`=1 for exactly one cycle. The FSM then returns to IDLE.
- `sample_valid` in any non-IDLE state drops the sample and sets `overrun`.
- `overrun` is cleared only by `clr_overrun` or `rst`. If set and clear occur in the same cycle, set wins.
- Changes to error or gain inputs after the snapshot do not affect the current cycle's result.

## Timing
- Reset values: all outputs 0, state IDLE. Because `sample_ready` is combinational from state, it reads 1 during reset.
- Reset mid-operation: the FSM returns to IDLE immediately, and snapshot, accumulator and shadow registers clear. No `u_valid` is produced for the aborted sample.
- Accepting edge E0; `err_en` is high in the cycle after E0.
- Snapshot occurs at edge E(1+ERR_LAT).
- `u_valid` and new `u_*` are visible after edge E(10+ERR_LAT); this is 11 cycles for the default.
- Minimum spacing between accepted samples is 12+ERR_LAT edges. A `sample_valid` on the edge that returns the FSM to IDLE is not accepted; it counts as an overrun.
- `u_*` hold their value between `u_valid` pulses.

## Structure
- Package `pid_pkg` holds:
  - the state enum {IDLE, ERR, WAIT, MAC, OUT}
  - term index constants TERM_P=0, TERM_I=1, TERM_D=2
  - axis index constants
  - default width localparams (W, KW, KFRAC, OW)
- Sub-module `pid_mac` contains the signed multiplier, accumulator with load/add control, and the shift/saturate stage. The sequencer owns the FSM, counters, snapshot and shadow registers.

## Test plan
- kp_pitch=256, all other gains 0, p_err pitch=100 → `u_pitch`=100, `u_valid` pulse 11 edges after acceptance, `err_en` high exactly 1 cycle.
- Pitch errors p=100, i=150, d=−50 with kp=512, ki=128, kd=−256 → `u_pitch`=325, `sat`=0; roll and yaw at 0 errors give 0.
- p_err=0x7FFFFF, kp=256 → `u_pitch`=32767, `sat[0]`=1. Then p_err=0x800000 → −32768, `sat[0]`=1.
- `sample_valid` re-asserted during MAC → `overrun`=1 and only one `u_valid`. `clr_overrun` → 0. Simultaneous set and clear → 1.
- `rst` pulse during MAC k=4 → all outputs 0, no `u_valid`, `sample_ready`=1 after deassert. Next sample then completes normally.
- ERR_LAT=3 → snapshot at E4 and `u_valid` after E13. Errors changed one cycle after the snapshot do not alter the result.
